// File: rtl/fpu_pkg.sv
// Shared FP32 definitions for the multiplier arbiter block.
package fpu_pkg;
    localparam int MUL_LAT_DEF = 4;
    localparam int FP32_W      = 32;

    // One multiplier result as stored in a per-requester FIFO.
    typedef struct packed {
        logic [FP32_W-1:0] data;
        logic              ovf;
        logic              unf;
    } fp_res_t;
endpackage

// File: rtl/fpu_mul_res_fifo.sv
// Per-requester result FIFO; the head entry is presented directly from storage.
module fpu_mul_res_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  logic    pop,
    input  fp_res_t din,
    output fp_res_t dout,
    output logic    empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fp_res_t         mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            full;
    logic            do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage, wrapping pointers and occupancy; reset clears storage so the head reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop)
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (!do_push && do_pop)
                count <= count - CW'(1);
        end
    end
endmodule

// File: rtl/fpu_mul_arbiter.sv
// Two-requester arbiter in front of a shared pipelined FP32 multiplier.
// Credits reserve result-FIFO space at grant time, so an exiting tag always has room.
module fpu_mul_arbiter
    import fpu_pkg::*;
#(
    parameter int MUL_LAT   = MUL_LAT_DEF,
    parameter int RES_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        res0_valid,
    input  logic        res0_ready,
    output logic [31:0] res0_data,
    output logic        res0_ovf,
    output logic        res0_unf,
    output logic        res1_valid,
    input  logic        res1_ready,
    output logic [31:0] res1_data,
    output logic        res1_ovf,
    output logic        res1_unf,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_result,
    input  logic        mul_overflow,
    input  logic        mul_underflow
);
    localparam int NREQ = 2;
    localparam int CW   = $clog2(RES_DEPTH + 1);

    logic [NREQ-1:0]             req_valid, res_ready, res_valid, empty;
    logic [NREQ-1:0]             elig, gnt, push, pop;
    logic [NREQ-1:0][FP32_W-1:0] req_a, req_b;
    fp_res_t                     res_head [NREQ];
    fp_res_t                     mul_res;
    logic                        last_grant;
    logic [MUL_LAT-1:0]          tag_vld, tag_id;

    assign req_valid = {req1_valid, req0_valid};
    assign res_ready = {res1_ready, res0_ready};
    assign req_a     = {req1_a, req0_a};
    assign req_b     = {req1_b, req0_b};
    assign mul_res   = {mul_result, mul_overflow, mul_underflow};

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign res0_valid = res_valid[0];
    assign res1_valid = res_valid[1];
    assign res0_data  = res_head[0].data;
    assign res0_ovf   = res_head[0].ovf;
    assign res0_unf   = res_head[0].unf;
    assign res1_data  = res_head[1].data;
    assign res1_ovf   = res_head[1].ovf;
    assign res1_unf   = res_head[1].unf;

    // Per-requester credit, eligibility and result FIFO.
    for (genvar n = 0; n < NREQ; n++) begin : g_req
        logic [CW-1:0] credit;

        // Gated by rst_n so ready drops the instant reset asserts.
        assign elig[n]      = rst_n && req_valid[n] && (credit < CW'(RES_DEPTH));
        assign push[n]      = tag_vld[MUL_LAT-1] && (tag_id[MUL_LAT-1] == 1'(n));
        assign pop[n]       = res_valid[n] && res_ready[n];
        assign res_valid[n] = !empty[n];

        // Credit counts ops in flight plus buffered results; grant and pop together cancel.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                credit <= '0;
            else if (gnt[n] && !pop[n])
                credit <= credit + CW'(1);
            else if (!gnt[n] && pop[n])
                credit <= credit - CW'(1);
        end

        fpu_mul_res_fifo #(.DEPTH(RES_DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[n]),
            .pop   (pop[n]),
            .din   (mul_res),
            .dout  (res_head[n]),
            .empty (empty[n])
        );
    end

    // Round-robin grant on a tie, operand mux to the multiplier; no grant sends a zero bubble.
    always_comb begin
        gnt   = elig;
        mul_a = '0;
        mul_b = '0;
        if (&elig)
            gnt = last_grant ? 2'b01 : 2'b10;
        if (gnt[1]) begin
            mul_a = req_a[1];
            mul_b = req_b[1];
        end else if (gnt[0]) begin
            mul_a = req_a[0];
            mul_b = req_b[0];
        end
    end

    // Last-grant pointer moves only when something is granted; reset favours req0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= 1'b1;
        else if (|gnt)
            last_grant <= gnt[1];
    end

    // Tag pipeline tracks which requester owns each multiplier stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            tag_vld[0] <= |gnt;
            tag_id[0]  <= gnt[1];
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end
endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Directed bench for fpu_mul_arbiter with a behavioural MUL_LAT-cycle FP32 multiplier.
module tb_fpu_mul_arbiter;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        res0_valid, res0_ready, res1_valid, res1_ready;
    logic [31:0] res0_data, res1_data;
    logic        res0_ovf, res0_unf, res1_ovf, res1_unf;
    logic [31:0] mul_a, mul_b, mul_result;
    logic        mul_overflow, mul_underflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fpu_mul_arbiter #(.MUL_LAT(LAT), .RES_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .res0_valid(res0_valid), .res0_ready(res0_ready), .res0_data(res0_data),
        .res0_ovf(res0_ovf), .res0_unf(res0_unf),
        .res1_valid(res1_valid), .res1_ready(res1_ready), .res1_data(res1_data),
        .res1_ovf(res1_ovf), .res1_unf(res1_unf),
        .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result), .mul_overflow(mul_overflow), .mul_underflow(mul_underflow)
    );

    // Truncating FP32 multiply: {data, ovf, unf}; zero/denormal inputs give zero.
    function automatic logic [33:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] p;
        logic [22:0] m;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0, 2'b00};
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            e = e + 1;
            m = p[46:24];
        end else begin
            m = p[45:23];
        end
        if (e >= 255) return {s, 8'hFF, 23'd0, 2'b10};
        if (e <= 0) return {s, 31'd0, 2'b01};
        return {s, e[7:0], m, 2'b00};
    endfunction

    logic [33:0] mp [LAT];
    always @(posedge clk) begin
        mp[0] <= fmul(mul_a, mul_b);
        for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
    end
    assign {mul_result, mul_overflow, mul_underflow} = mp[LAT-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // A push into a full FIFO must never happen.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("fifo0_push_full", 32'(dut.g_req[0].u_fifo.push && dut.g_req[0].u_fifo.full), 32'd0);
            check("fifo1_push_full", 32'(dut.g_req[1].u_fifo.push && dut.g_req[1].u_fifo.full), 32'd0);
        end
    end

    logic [31:0] bp_b   [5] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    logic [31:0] drain1 [4] = '{32'h40C00000, 32'h41000000, 32'h41200000, 32'h41400000};

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = 32'h40000000; req0_b = 32'h40000000;
        req1_valid = 1'b1; req1_a = 32'h40000000; req1_b = 32'h40000000;
        res0_ready = 1'b0; res1_ready = 1'b0;
        #2;
        // Reset state: valid requests must not see ready while in reset.
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        check("rst_res0_valid", 32'(res0_valid), 32'd0);
        check("rst_res1_valid", 32'(res1_valid), 32'd0);
        check("rst_res0_data", res0_data, 32'd0);
        check("rst_res1_data", res1_data, 32'd0);
        check("rst_res0_flags", 32'({res0_ovf, res0_unf, res1_ovf, res1_unf}), 32'd0);
        check("rst_mul_a", mul_a, 32'd0);
        check("rst_mul_b", mul_b, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step(); step();
        rst_n = 1'b1;
        #1;

        // Single op: 2.0 x 3.0 = 6.0, visible after edge k+4.
        req0_valid = 1'b1; req0_a = 32'h40000000; req0_b = 32'h40400000;
        #1;
        check("single_ready", 32'(req0_ready), 32'd1);
        check("single_mul_a", mul_a, 32'h40000000);
        check("single_mul_b", mul_b, 32'h40400000);
        step();
        req0_valid = 1'b0;
        #1;
        check("idle_mul_a", mul_a, 32'd0);
        step(); step(); step();
        check("single_early", 32'(res0_valid), 32'd0);
        step();
        check("single_valid", 32'(res0_valid), 32'd1);
        check("single_data", res0_data, 32'h40C00000);
        check("single_flags", 32'({res0_ovf, res0_unf}), 32'd0);
        res0_ready = 1'b1;
        step();
        res0_ready = 1'b0;
        check("single_popped", 32'(res0_valid), 32'd0);

        // Fresh reset so req0 wins the first tie.
        rst_n = 1'b0; #1; rst_n = 1'b1; #1;

        // Contention: grants alternate 0,1,0,1.
        req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000;
        req1_valid = 1'b1; req1_a = 32'h40000000; req1_b = 32'h40000000;
        #1;
        check("cont0_r0", 32'(req0_ready), 32'd1);
        check("cont0_r1", 32'(req1_ready), 32'd0);
        step();
        req0_b = 32'h40800000;
        #1;
        check("cont1_r0", 32'(req0_ready), 32'd0);
        check("cont1_r1", 32'(req1_ready), 32'd1);
        check("cont1_mul_a", mul_a, 32'h40000000);
        step();
        req1_a = 32'h40400000; req1_b = 32'h40400000;
        #1;
        check("cont2_r0", 32'(req0_ready), 32'd1);
        check("cont2_r1", 32'(req1_ready), 32'd0);
        check("cont2_mul_b", mul_b, 32'h40800000);
        step();
        req0_b = 32'h40A00000;
        #1;
        check("cont3_r0", 32'(req0_ready), 32'd0);
        check("cont3_r1", 32'(req1_ready), 32'd1);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        step(); step(); step(); step();
        check("cont_res0_a", res0_data, 32'h40000000);
        check("cont_res1_a", res1_data, 32'h40800000);
        res0_ready = 1'b1; res1_ready = 1'b1;
        step();
        check("cont_res0_b", res0_data, 32'h40800000);
        check("cont_res1_b", res1_data, 32'h41100000);
        check("cont_res0_bv", 32'(res0_valid), 32'd1);
        check("cont_res1_bv", 32'(res1_valid), 32'd1);
        step();
        res0_ready = 1'b0; res1_ready = 1'b0;
        check("cont_res0_empty", 32'(res0_valid), 32'd0);
        check("cont_res1_empty", 32'(res1_valid), 32'd0);

        // Backpressure on res1: four back-to-back grants, then blocked.
        req1_valid = 1'b1; req1_a = 32'h40000000;
        for (int i = 0; i < 4; i++) begin
            req1_b = bp_b[i];
            #1;
            check("bp_grant", 32'(req1_ready), 32'd1);
            step();
        end
        req1_b = bp_b[4];
        req0_valid = 1'b1; req0_a = 32'h7F000000; req0_b = 32'h7F000000;
        #1;
        check("bp_blocked", 32'(req1_ready), 32'd0);
        check("bp_req0_free", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        check("bp_head_valid", 32'(res1_valid), 32'd1);
        check("bp_head_data", res1_data, 32'h40000000);
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_hold_ready", 32'(req1_ready), 32'd0);
            check("bp_hold_data", res1_data, 32'h40000000);
        end
        // Overflow: huge x huge saturates to +inf.
        check("ovf_valid", 32'(res0_valid), 32'd1);
        check("ovf_data", res0_data, 32'h7F800000);
        check("ovf_flag", 32'(res0_ovf), 32'd1);
        check("ovf_unf", 32'(res0_unf), 32'd0);
        res0_ready = 1'b1;
        step();
        res0_ready = 1'b0;

        // One pop re-enables one grant; grant+pop together keep credit at 3.
        res1_ready = 1'b1;
        #1;
        check("pop_still_blocked", 32'(req1_ready), 32'd0);
        step();
        check("reenable_ready", 32'(req1_ready), 32'd1);
        check("reenable_head", res1_data, 32'h40800000);
        step();
        res1_ready = 1'b0;
        req1_b = 32'h40C00000;
        #1;
        check("credit_unchanged", 32'(req1_ready), 32'd1);
        step();
        check("credit_full_again", 32'(req1_ready), 32'd0);
        req1_valid = 1'b0;

        // Drain res1 in issue order.
        res1_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 10 && !res1_valid; w++) step();
            check("drain_valid", 32'(res1_valid), 32'd1);
            check("drain_data", res1_data, drain1[k]);
            step();
        end
        res1_ready = 1'b0;
        check("drain_empty", 32'(res1_valid), 32'd0);

        // Reset with three ops in flight.
        req0_valid = 1'b1; req0_a = 32'h40000000; req0_b = 32'h40000000;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("inflight_grant", 32'(req0_ready), 32'd1);
            step();
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(req0_ready), 32'd0);
        check("midrst_mul_a", mul_a, 32'd0);
        check("midrst_res0_valid", 32'(res0_valid), 32'd0);
        check("midrst_res0_data", res0_data, 32'd0);
        check("midrst_res1_data", res1_data, 32'd0);
        req0_valid = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("no_stale_res0", 32'(res0_valid), 32'd0);
            check("no_stale_res1", 32'(res1_valid), 32'd0);
        end
        req0_valid = 1'b1;
        #1;
        check("post_rst_ready", 32'(req0_ready), 32'd1);
        req0_valid = 1'b0;
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
